// File: rtl/controlador_botones_pkg.sv
// ============================================================================
// controlador_botones_pkg : shared types and width helpers for the button
// event controller.  Revision: 1.0
// ============================================================================
`default_nettype none

package controlador_botones_pkg;

  typedef enum logic [0:0] {
    LIBRE  = 1'b0,
    OFRECE = 1'b1
  } estado_t;

  // Width of the event index; a single button still needs one bit.
  function automatic int idw_f(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Width of the prescaler counter (0..p-1).
  function automatic int pre_w_f(input int p);
    return (p <= 1) ? 1 : $clog2(p);
  endfunction

endpackage

`default_nettype wire

// File: rtl/controlador_botones_filtro.sv
// ============================================================================
// filtro_flanco : per-button sampling shift register with registered
// falling-edge pulse.  Revision: 1.0
// ============================================================================
`default_nettype none

module filtro_flanco #(
  parameter int FILTRO = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic boton,
  output logic flanco_o
);

  logic [FILTRO-1:0] muestras_q, muestras_d;
  logic              flanco_q, flanco_d;

  // The pulse is computed from the post-shift contents so it appears the
  // cycle after the sampling tick.
  always_comb begin
    muestras_d = muestras_q;
    if (tick) begin
      muestras_d = {muestras_q[FILTRO-2:0], boton};
    end
    flanco_d = tick & ~muestras_d[0] & (&muestras_d[FILTRO-1:1]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      muestras_q <= '0;
      flanco_q   <= 1'b0;
    end else begin
      muestras_q <= muestras_d;
      flanco_q   <= flanco_d;
    end
  end

  assign flanco_o = flanco_q;

endmodule

`default_nettype wire

// File: rtl/controlador_botones.sv
// ============================================================================
// controlador_botones : debounced falling-edge collector and valid/ready
// event serialiser.  Optional macro ROUND_ROBIN_EN selects round-robin
// arbitration instead of fixed lowest-index priority.  Revision: 1.0
// ============================================================================
`default_nettype none

module controlador_botones
  import controlador_botones_pkg::*;
#(
  parameter  int N_BOTONES = 4,
  parameter  int FILTRO    = 4,
  parameter  int PRESCALER = 1000,
  localparam int IDW       = idw_f(N_BOTONES)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_BOTONES-1:0] botones,
  output logic                 evento_valid,
  output logic [IDW-1:0]       evento_id,
  input  logic                 evento_ready,
  output logic [N_BOTONES-1:0] pendientes,
  output logic                 overflow
);

  localparam int            PW      = pre_w_f(PRESCALER);
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALER - 1);

  logic [PW-1:0]        cnt_q, cnt_d;
  logic                 tick;
  logic [N_BOTONES-1:0] flancos;
  logic [N_BOTONES-1:0] pend_q, pend_d, clr;
  logic                 ovf_q, ovf_d;
  estado_t              est_q, est_d;
  logic [IDW-1:0]       id_q, id_d;
  logic [IDW-1:0]       gan;
  logic                 hay;
  logic                 acepta;

  assign tick  = (cnt_q == PRE_MAX);
  assign cnt_d = tick ? '0 : cnt_q + PW'(1);

  generate
    for (genvar i = 0; i < N_BOTONES; i++) begin : g_filtro
      filtro_flanco #(
        .FILTRO (FILTRO)
      ) u_filtro (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .boton    (botones[i]),
        .flanco_o (flancos[i])
      );
    end
  endgenerate

  assign acepta = (est_q == OFRECE) & evento_ready;

  // A set on the same cycle as the clear wins; an edge on a bit that is
  // pending and not being cleared is dropped and flagged.
  always_comb begin
    clr = '0;
    for (int i = 0; i < N_BOTONES; i++) begin
      clr[i] = acepta && (id_q == IDW'(i));
    end
    pend_d = (pend_q & ~clr) | flancos;
    ovf_d  = |(flancos & pend_q & ~clr);
  end

`ifdef ROUND_ROBIN_EN
  logic [IDW-1:0] ult_q, ult_d;
  logic [IDW-1:0] gan_alto, gan_bajo;
  logic           hay_alto, hay_bajo;

  // Descending scan leaves the lowest candidate; prefer those above the
  // last grant, otherwise wrap to the lowest pending index.
  always_comb begin
    gan_alto = '0;
    gan_bajo = '0;
    hay_alto = 1'b0;
    hay_bajo = 1'b0;
    for (int j = N_BOTONES - 1; j >= 0; j--) begin
      if (pend_q[j]) begin
        gan_bajo = IDW'(j);
        hay_bajo = 1'b1;
        if (IDW'(j) > ult_q) begin
          gan_alto = IDW'(j);
          hay_alto = 1'b1;
        end
      end
    end
    gan = hay_alto ? gan_alto : gan_bajo;
    hay = hay_bajo;
  end

  assign ult_d = acepta ? id_q : ult_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ult_q <= IDW'(N_BOTONES - 1);
    end else begin
      ult_q <= ult_d;
    end
  end
`else
  always_comb begin
    gan = '0;
    hay = 1'b0;
    for (int j = N_BOTONES - 1; j >= 0; j--) begin
      if (pend_q[j]) begin
        gan = IDW'(j);
        hay = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    est_d = est_q;
    id_d  = id_q;
    case (est_q)
      LIBRE: begin
        if (hay) begin
          id_d  = gan;
          est_d = OFRECE;
        end
      end
      OFRECE: begin
        if (evento_ready) begin
          est_d = LIBRE;
        end
      end
      default: est_d = LIBRE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      pend_q <= '0;
      ovf_q  <= 1'b0;
      est_q  <= LIBRE;
      id_q   <= '0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
      est_q  <= est_d;
      id_q   <= id_d;
    end
  end

  assign evento_valid = (est_q == OFRECE);
  assign evento_id    = id_q;
  assign pendientes   = pend_q;
  assign overflow     = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_controlador_botones.sv
// ============================================================================
// tb_controlador_botones : directed self-checking bench, PRESCALER=4,
// FILTRO=4, N_BOTONES=4.  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_controlador_botones;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] botones;
  logic       evento_valid;
  logic [1:0] evento_id;
  logic       evento_ready;
  logic [3:0] pendientes;
  logic       overflow;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    logic       rst;
    logic [3:0] b;
    logic       rdy;
    int         n;
    logic       ev;
    logic [1:0] id;
    logic [3:0] pe;
    logic       ov;
  } vec_t;

  vec_t tabla [10];

  controlador_botones #(
    .N_BOTONES (4),
    .FILTRO    (4),
    .PRESCALER (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .botones      (botones),
    .evento_valid (evento_valid),
    .evento_id    (evento_id),
    .evento_ready (evento_ready),
    .pendientes   (pendientes),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    botones      = 4'b0000;
    evento_ready = 1'b0;
    repeat (2) step();
    reset = 1'b0;
    cyc   = 0;
  endtask

  // Three high ticks then one low tick; returns one cycle after the low tick.
  task automatic press(input logic [3:0] mask);
    while (cyc % 4 != 0) step();
    botones = mask;
    repeat (12) step();
    botones = 4'b0000;
    repeat (4) step();
  endtask

  initial begin
    int     ovf_cnt;
    int     val_cnt;
    logic   estable;
    int     got[$];
    int     exp_b[5];

    reset        = 1'b1;
    botones      = 4'b0000;
    evento_ready = 1'b0;

    //             rst   botones  rdy  n   ev    id     pend     ovf
    tabla[0] = '{1'b1, 4'b0000, 1'b0, 2, 1'b0, 2'd0, 4'b0000, 1'b0};
    tabla[1] = '{1'b0, 4'b0001, 1'b0, 12, 1'b0, 2'd0, 4'b0000, 1'b0};
    tabla[2] = '{1'b0, 4'b0000, 1'b0, 4, 1'b0, 2'd0, 4'b0000, 1'b0};
    tabla[3] = '{1'b0, 4'b0000, 1'b0, 1, 1'b0, 2'd0, 4'b0001, 1'b0};
    tabla[4] = '{1'b0, 4'b0000, 1'b0, 1, 1'b1, 2'd0, 4'b0001, 1'b0};
    tabla[5] = '{1'b0, 4'b0000, 1'b1, 1, 1'b0, 2'd0, 4'b0000, 1'b0};
    tabla[6] = '{1'b0, 4'b0000, 1'b0, 5, 1'b0, 2'd0, 4'b0000, 1'b0};
    tabla[7] = '{1'b0, 4'b0010, 1'b0, 8, 1'b0, 2'd0, 4'b0000, 1'b0};
    tabla[8] = '{1'b0, 4'b0000, 1'b0, 8, 1'b0, 2'd0, 4'b0000, 1'b0};
    tabla[9] = '{1'b0, 4'b0000, 1'b0, 4, 1'b0, 2'd0, 4'b0000, 1'b0};

    for (int v = 0; v < 10; v++) begin
      reset        = tabla[v].rst;
      botones      = tabla[v].b;
      evento_ready = tabla[v].rdy;
      repeat (tabla[v].n) step();
      chk($sformatf("vec%0d_valid", v), 32'(evento_valid), 32'(tabla[v].ev));
      if (tabla[v].ev) chk($sformatf("vec%0d_id", v), 32'(evento_id), 32'(tabla[v].id));
      chk($sformatf("vec%0d_pend", v), 32'(pendientes), 32'(tabla[v].pe));
      chk($sformatf("vec%0d_ovf", v), 32'(overflow), 32'(tabla[v].ov));
    end
    evento_ready = 1'b0;

    // Backpressure with buttons 2 and 3 firing together.
    do_reset();
    press(4'b1100);
    repeat (2) step();
    chk("bp_valid", 32'(evento_valid), 32'd1);
    chk("bp_id", 32'(evento_id), 32'd2);
    chk("bp_pend", 32'(pendientes), 32'hC);
    estable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      if (!(evento_valid === 1'b1 && evento_id === 2'd2 && pendientes === 4'b1100)) estable = 1'b0;
    end
    chk("bp_hold_stable", 32'(estable), 32'd1);
    evento_ready = 1'b1;
    step();
    evento_ready = 1'b0;
    chk("bp_acc_valid", 32'(evento_valid), 32'd0);
    chk("bp_acc_pend", 32'(pendientes), 32'h8);
    step();
    chk("bp_next_valid", 32'(evento_valid), 32'd1);
    chk("bp_next_id", 32'(evento_id), 32'd3);
    evento_ready = 1'b1;
    step();
    evento_ready = 1'b0;
    chk("bp_done_pend", 32'(pendientes), 32'h0);

    // Overflow: second edge on pending button 1.
    do_reset();
    press(4'b0010);
    repeat (2) step();
    chk("ovf_first_valid", 32'(evento_valid), 32'd1);
    chk("ovf_first_id", 32'(evento_id), 32'd1);
    press(4'b0010);
    chk("ovf_pre", 32'(overflow), 32'd0);
    ovf_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (overflow === 1'b1) ovf_cnt++;
    end
    chk("ovf_pulses", 32'(ovf_cnt), 32'd1);
    chk("ovf_pend", 32'(pendientes), 32'h2);
    evento_ready = 1'b1;
    step();
    evento_ready = 1'b0;
    chk("ovf_acc_pend", 32'(pendientes), 32'h0);
    val_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (evento_valid === 1'b1) val_cnt++;
    end
    chk("ovf_single_event", 32'(val_cnt), 32'd0);

    // All four pending, ready held high.
    do_reset();
    evento_ready = 1'b1;
    press(4'b1111);
    got.delete();
    for (int i = 0; i < 12; i++) begin
      if (evento_valid === 1'b1) got.push_back(int'(evento_id));
      step();
    end
    evento_ready = 1'b0;
    chk("arbA_count", 32'(got.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < got.size()) chk($sformatf("arbA_order%0d", i), 32'(got[i]), 32'(i));
    end

    // Button 0 re-pended after its grant while 1 is being offered.
    do_reset();
    press(4'b1111);
    repeat (2) step();
    chk("arbB_first_id", 32'(evento_id), 32'd0);
    chk("arbB_pend_all", 32'(pendientes), 32'hF);
    got.delete();
    got.push_back(int'(evento_id));
    evento_ready = 1'b1;
    step();
    evento_ready = 1'b0;
    chk("arbB_pend_after0", 32'(pendientes), 32'hE);
    step();
    got.push_back(int'(evento_id));
    press(4'b0001);
    repeat (2) step();
    chk("arbB_repend", 32'(pendientes), 32'hF);
    evento_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (evento_valid === 1'b1) got.push_back(int'(evento_id));
    end
    evento_ready = 1'b0;
`ifdef ROUND_ROBIN_EN
    exp_b = '{0, 1, 2, 3, 0};
`else
    exp_b = '{0, 1, 0, 2, 3};
`endif
    chk("arbB_count", 32'(got.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < got.size()) chk($sformatf("arbB_order%0d", i), 32'(got[i]), 32'(exp_b[i]));
    end

    // Reset while an offer is outstanding.
    do_reset();
    press(4'b0001);
    repeat (2) step();
    chk("rst_pre_valid", 32'(evento_valid), 32'd1);
    reset = 1'b1;
    step();
    chk("rst_valid", 32'(evento_valid), 32'd0);
    chk("rst_id", 32'(evento_id), 32'd0);
    chk("rst_pend", 32'(pendientes), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    reset = 1'b0;
    val_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (evento_valid !== 1'b0 || pendientes !== 4'b0000) val_cnt++;
    end
    chk("rst_quiet", 32'(val_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/controlador_botones.md
# controlador_botones

Collects debounced falling-edge events from N push-buttons and serialises them to one consumer through a valid/ready handshake. Each button is sampled on a shared prescaled tick through a FILTRO-deep shift register. A falling edge is declared when the newest sample is 0 and the FILTRO-1 older samples are all 1. Detected events latch into per-button pending bits, and an arbiter offers them one at a time to the downstream control FSM.

## Interface
- N_BOTONES, 4, number of button inputs (1..16)
- FILTRO, 4, shift-register depth per button (≥2)
- PRESCALER, 1000, clk cycles per sampling tick (≥1)
- clk  in  1  system clock, all logic on posedge
- reset  in  1  synchronous, active-high reset
- botones  in  N_BOTONES  raw button levels (already synchronised upstream)
- evento_valid  out  1  an event is offered
- evento_id  out  IDW  index of offered button; IDW = max(1, $clog2(N_BOTONES))
- evento_ready  in  1  consumer accepts the offered event
- pendientes  out  N_BOTONES  registered pending bit per button
- overflow  out  1  one-cycle pulse: an edge hit a button whose pending bit was already set

## Operation
- Prescaler: counter 0..PRESCALER-1. `tick` is high when count == PRESCALER-1, then the counter wraps to 0. With PRESCALER=1, tick is high every cycle.
- Filter, per button, on tick only: shift the register, sample[0] ← botones[i].
- Edge detection: edge_i = tick & (sample[0]==0) & (sample[FILTRO-1:1] all 1). The shift happens first; detection evaluates the post-shift contents in the cycle after tick.
- Pending: set on edge_i, cleared on acceptance of i. If set and clear hit the same bit in the same cycle, set wins and the bit stays 1. An edge on an already-pending bit (not being accepted that cycle) pulses overflow; the event is dropped and the bit remains set.
- Arbiter FSM, two states:
  - LIBRE: if any pending bit is set, select a winner, register evento_id, go to OFRECE.
  - OFRECE: evento_valid=1. evento_id stays stable until accepted. On evento_valid & evento_ready, clear pendientes[id] and return to LIBRE.
  - The arbiter never withdraws an offer. New edges arriving during OFRECE only set pending bits.
- Reset: every output is 0 (evento_valid, evento_id, pendientes, overflow). Shift registers are all 0, the prescaler is 0, and the FSM is in LIBRE. All-zero filters cannot produce an edge until FILTRO-1 ones have been sampled. Reset asserted during OFRECE discards the offer and all pending events.

## Timing
- Tick at cycle T shifts the sample. Edge is evaluated at T+1, pending is set visible at T+2, and evento_valid rises at T+3 if the FSM is in LIBRE.
- Acceptance at cycle A: evento_valid=0 and the pending bit is cleared at A+1. The next offer appears no earlier than A+2 (one LIBRE bubble).
- The minimum detectable release-to-press interval is FILTRO-1 consecutive high ticks followed by one low tick.
- overflow is registered and pulses at T+2 for an edge evaluated at T+1.

## Configuration
- ROUND_ROBIN_EN defined: the winner is the first pending index strictly above the last granted index, wrapping modulo N_BOTONES. The last-granted pointer resets to N_BOTONES-1, so index 0 is checked first after reset.
- ROUND_ROBIN_EN undefined: fixed priority, lowest pending index wins, and no pointer register is built.

## Structure
- Package controlador_botones_pkg holds:
  - the state enum {LIBRE, OFRECE};
  - an IDW helper function;
  - the prescaler width localparam computation.
- Sub-module filtro_flanco, one instance per button:
  - inputs: clk, reset, tick, boton;
  - parameter: FILTRO;
  - output: registered edge pulse.
- Prescaler, pending register, arbiter and FSM live in the top module.

## Test plan
- Single press, defaults with PRESCALER=4: boton0 high for 3 ticks, then low → evento_valid=1 with evento_id=0 exactly 3 cycles after the low-sampling tick; ready=1 → valid drops next cycle and pendientes=0000.
- Glitch rejection: boton1 high for 2 ticks, then low → no event and pendientes stays 0.
- Backpressure: evento_ready=0 for 50 cycles while buttons 2 and 3 fire → valid held with id=2 stable, pendientes=1100; release ready → id=2 accepted, then id=3 offered two cycles later.
- Overflow: two qualifying edges on button 1 with ready held 0 → one overflow pulse and only one event is delivered.
- Arbitration, all four pending with ready=1 continuously: with ROUND_ROBIN_EN the order is 0,1,2,3; with 0 re-pended after its grant, the order is 0,1,2,3,0. Without ROUND_ROBIN_EN, re-pended 0 beats 2 and 3.
- Reset mid-offer: assert reset in OFRECE → next cycle all outputs are 0 and no event follows until a new qualifying edge.
